// File: rtl/nxn_matrix_multiplier.sv
// -----------------------------------------------------------------------------
// nxn_matrix_multiplier
//   Computes C = A*B (mode 0) or C = A*B + C_prev (mode 1) for N x N matrices of
//   IEEE-754 single-precision values. One multiplier and one adder are shared
//   across all N*N*N multiply/add pairs. Elements are processed in row-major
//   order and each dot product is summed for k = 0..N-1.
//
//   Ports (top):
//     input_Clk      sole clock, rising edge
//     input_Reset    synchronous, active-high reset
//     input_Stable   A, B and mode valid; start request (ignored while busy)
//     input_Mode     0: C = A*B, 1: C = A*B + held output_C
//     input_A/B      N*N*32, element (i,j) at bits [(i*N+j)*32 +: 32]
//     input_C_Ack    consumer has taken output_C (only honoured in DONE)
//     output_AB_Ack  one-cycle pulse after operands are captured
//     output_Busy    high from capture until the output handshake completes
//     output_Stable  output_C valid, held until acknowledged
//     output_C       result matrix, same layout as input_A
//
//   Also contains the two arithmetic helpers:
//     single_multiplier  z = a*b  (strobe/ack handshake per operand and result)
//     adder              z = a+b  (same handshake, result_ready/result_ack)
//   Both round to nearest-even, flush subnormals to zero, and return the
//   default quiet NaN for invalid operations.
// -----------------------------------------------------------------------------

module single_multiplier (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_a,
    input  logic        i_a_stb,
    output logic        o_a_ack,
    input  logic [31:0] i_b,
    input  logic        i_b_stb,
    output logic        o_b_ack,
    output logic [31:0] o_z,
    output logic        o_z_stb,
    input  logic        i_z_ack
);
    typedef enum logic [1:0] {S_IN, S_CALC, S_OUT} state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      r_state, w_next;
    logic [31:0] r_a, r_b, r_z;
    logic        r_have_a, r_have_b;

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [47:0]       p;
        logic [22:0]       m;
        logic              g, st;
        logic [23:0]       mr;
        logic signed [9:0] e;
        s = a[31] ^ b[31];
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0)) begin
            fp_mul = QNAN;
        end else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            fp_mul = (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? QNAN : {s, 8'hFF, 23'd0};
        end else if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            fp_mul = {s, 31'd0};
        end else begin
            p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
            e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
            // Product of two 1.x mantissas lies in [1,4); normalise to 1.x.
            if (p[47]) begin
                m = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
            end else begin
                m = p[45:23]; g = p[22]; st = |p[21:0];
            end
            mr = {1'b0, m} + {23'd0, (g && (st || m[0]))};
            if (mr[23]) e = e + 10'sd1;  // rounding carried into the exponent
            if (e >= 10'sd255)    fp_mul = {s, 8'hFF, 23'd0};
            else if (e <= 10'sd0) fp_mul = {s, 31'd0};
            else                  fp_mul = {s, e[7:0], mr[22:0]};
        end
    endfunction

    assign o_a_ack = (r_state == S_IN) && !r_have_a;
    assign o_b_ack = (r_state == S_IN) && !r_have_b;
    assign o_z     = r_z;
    assign o_z_stb = (r_state == S_OUT);

    // NOTE: sequential state is written with non-blocking (<=) so every flop
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IN;
        else          r_state <= w_next;
    end

    // NOTE: every signal written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IN:    if (r_have_a && r_have_b) w_next = S_CALC;
            S_CALC:  w_next = S_OUT;
            S_OUT:   if (i_z_ack) w_next = S_IN;
            default: w_next = S_IN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_have_a <= 1'b0;
            r_have_b <= 1'b0;
            r_z      <= '0;
        end else begin
            if (i_a_stb && o_a_ack) r_have_a <= 1'b1;
            if (i_b_stb && o_b_ack) r_have_b <= 1'b1;
            if (r_state == S_CALC) r_z <= fp_mul(r_a, r_b);
            if (r_state == S_OUT && i_z_ack) begin
                r_have_a <= 1'b0;
                r_have_b <= 1'b0;
            end
        end
    end

    // NOTE: operand holding registers are deliberately not reset: they are only
    // read after a handshake has loaded them, so a reset would cost area for nothing.
    always_ff @(posedge i_clk) begin
        if (i_a_stb && o_a_ack) r_a <= i_a;
        if (i_b_stb && o_b_ack) r_b <= i_b;
    end
endmodule

module adder (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_a,
    input  logic        i_a_stb,
    output logic        o_a_ack,
    input  logic [31:0] i_b,
    input  logic        i_b_stb,
    output logic        o_b_ack,
    output logic [31:0] o_result,
    output logic        o_result_ready,
    input  logic        i_result_ack
);
    typedef enum logic [1:0] {S_IN, S_CALC, S_OUT} state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      r_state, w_next;
    logic [31:0] r_a, r_b, r_z;
    logic        r_have_a, r_have_b;

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]       a, b;
        logic [26:0]       ma, mb, mb_sh, m;
        logic [27:0]       sum;
        logic [7:0]        d;
        logic [24:0]       mr;
        logic              rnd;
        logic signed [9:0] e;
        int                lz;
        // Order operands so |a| >= |b|; the result takes a's sign.
        if (x[30:0] >= y[30:0]) begin a = x; b = y; end
        else                    begin a = y; b = x; end
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0)) begin
            fp_add = QNAN;
        end else if (a[30:23] == 8'hFF) begin
            fp_add = (b[30:23] == 8'hFF && a[31] != b[31]) ? QNAN : a;
        end else if (b[30:23] == 8'd0) begin
            fp_add = (a[30:23] == 8'd0) ? {a[31] & b[31], 31'd0} : a;
        end else begin
            // 24-bit mantissa plus guard, round and sticky bits.
            d  = a[30:23] - b[30:23];
            ma = {1'b1, a[22:0], 3'b000};
            mb = {1'b1, b[22:0], 3'b000};
            if (d > 8'd26) mb_sh = 27'd1;
            else           mb_sh = (mb >> d) | {26'd0, |(mb & ~(27'h7FF_FFFF << d))};
            e = $signed({2'b00, a[30:23]});
            if (a[31] == b[31]) begin
                sum = {1'b0, ma} + {1'b0, mb_sh};
                if (sum[27]) begin
                    m = sum[27:1] | {26'd0, sum[0]};
                    e = e + 10'sd1;
                end else begin
                    m = sum[26:0];
                end
            end else begin
                m  = ma - mb_sh;  // never negative because |a| >= |b|
                lz = 27;
                for (int n = 0; n < 27; n++) if (m[n]) lz = 26 - n;
                m = m << lz;
                e = e - $signed(10'(lz));
            end
            rnd = m[2] && (m[1] || m[0] || m[3]);
            mr  = {1'b0, m[26:3]} + {24'd0, rnd};
            if (mr[24]) begin
                mr = mr >> 1;
                e  = e + 10'sd1;
            end
            if (m == 27'd0)        fp_add = 32'd0;  // exact cancellation gives +0
            else if (e >= 10'sd255) fp_add = {a[31], 8'hFF, 23'd0};
            else if (e <= 10'sd0)   fp_add = {a[31], 31'd0};
            else                    fp_add = {a[31], e[7:0], mr[22:0]};
        end
    endfunction

    assign o_a_ack        = (r_state == S_IN) && !r_have_a;
    assign o_b_ack        = (r_state == S_IN) && !r_have_b;
    assign o_result       = r_z;
    assign o_result_ready = (r_state == S_OUT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IN;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IN:    if (r_have_a && r_have_b) w_next = S_CALC;
            S_CALC:  w_next = S_OUT;
            S_OUT:   if (i_result_ack) w_next = S_IN;
            default: w_next = S_IN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_have_a <= 1'b0;
            r_have_b <= 1'b0;
            r_z      <= '0;
        end else begin
            if (i_a_stb && o_a_ack) r_have_a <= 1'b1;
            if (i_b_stb && o_b_ack) r_have_b <= 1'b1;
            if (r_state == S_CALC) r_z <= fp_add(r_a, r_b);
            if (r_state == S_OUT && i_result_ack) begin
                r_have_a <= 1'b0;
                r_have_b <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_a_stb && o_a_ack) r_a <= i_a;
        if (i_b_stb && o_b_ack) r_b <= i_b;
    end
endmodule

module nxn_matrix_multiplier #(
    parameter int N = 2,
    parameter int W = 32
) (
    input  logic             input_Clk,
    input  logic             input_Reset,
    input  logic             input_Stable,
    input  logic             input_Mode,
    input  logic [N*N*W-1:0] input_A,
    input  logic [N*N*W-1:0] input_B,
    input  logic             input_C_Ack,
    output logic             output_AB_Ack,
    output logic             output_Busy,
    output logic             output_Stable,
    output logic [N*N*W-1:0] output_C
);
    localparam int               IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

    typedef enum logic [2:0] {IDLE, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, STORE, DONE} state_t;

    state_t           r_state, w_next;
    logic [N*N*W-1:0] r_a, r_b, r_c;
    logic             r_mode;
    logic [IDX_W-1:0] r_i, r_j, r_k;
    logic [W-1:0]     r_acc, r_prod;
    logic             r_ab_ack;
    logic             r_mul_a_seen, r_mul_b_seen, r_add_a_seen, r_add_b_seen;

    logic             w_rst_n;
    logic             w_mul_a_stb, w_mul_b_stb, w_mul_a_ack, w_mul_b_ack;
    logic             w_mul_z_stb, w_mul_z_ack;
    logic [W-1:0]     w_mul_z;
    logic             w_add_a_stb, w_add_b_stb, w_add_a_ack, w_add_b_ack;
    logic             w_add_rdy, w_add_r_ack;
    logic [W-1:0]     w_add_z;
    logic [W-1:0]     w_a_elem, w_b_elem;
    logic             w_row_end, w_last_elem;
    logic [IDX_W-1:0] w_next_i, w_next_j;

    assign w_rst_n  = ~input_Reset;
    assign w_a_elem = r_a[(int'(r_i) * N + int'(r_k)) * W +: W];
    assign w_b_elem = r_b[(int'(r_k) * N + int'(r_j)) * W +: W];

    // Row-major walk over the output elements; indices return to (0,0) after the last.
    assign w_row_end   = (r_j == LAST);
    assign w_last_elem = w_row_end && (r_i == LAST);
    assign w_next_j    = w_row_end ? '0 : r_j + 4'd1;
    assign w_next_i    = w_last_elem ? '0 : (w_row_end ? r_i + 4'd1 : r_i);

    single_multiplier u_mul (
        .i_clk   (input_Clk),
        .i_rst_n (w_rst_n),
        .i_a     (w_a_elem),
        .i_a_stb (w_mul_a_stb),
        .o_a_ack (w_mul_a_ack),
        .i_b     (w_b_elem),
        .i_b_stb (w_mul_b_stb),
        .o_b_ack (w_mul_b_ack),
        .o_z     (w_mul_z),
        .o_z_stb (w_mul_z_stb),
        .i_z_ack (w_mul_z_ack)
    );

    adder u_add (
        .i_clk          (input_Clk),
        .i_rst_n        (w_rst_n),
        .i_a            (r_acc),
        .i_a_stb        (w_add_a_stb),
        .o_a_ack        (w_add_a_ack),
        .i_b            (r_prod),
        .i_b_stb        (w_add_b_stb),
        .o_b_ack        (w_add_b_ack),
        .o_result       (w_add_z),
        .o_result_ready (w_add_rdy),
        .i_result_ack   (w_add_r_ack)
    );

    assign output_AB_Ack = r_ab_ack;
    assign output_Busy   = (r_state != IDLE);
    assign output_Stable = (r_state == DONE);
    assign output_C      = r_c;

    always_ff @(posedge input_Clk) begin
        if (input_Reset) r_state <= IDLE;
        else             r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_mul_a_stb = 1'b0;
        w_mul_b_stb = 1'b0;
        w_mul_z_ack = 1'b0;
        w_add_a_stb = 1'b0;
        w_add_b_stb = 1'b0;
        w_add_r_ack = 1'b0;
        unique case (r_state)
            IDLE: if (input_Stable) w_next = MUL_REQ;
            MUL_REQ: begin
                // Each operand strobe drops once its own ack has been seen.
                w_mul_a_stb = !r_mul_a_seen;
                w_mul_b_stb = !r_mul_b_seen;
                if ((r_mul_a_seen || w_mul_a_ack) && (r_mul_b_seen || w_mul_b_ack)) w_next = MUL_WAIT;
            end
            MUL_WAIT: begin
                w_mul_z_ack = w_mul_z_stb;
                if (w_mul_z_stb) w_next = ADD_REQ;
            end
            ADD_REQ: begin
                w_add_a_stb = !r_add_a_seen;
                w_add_b_stb = !r_add_b_seen;
                if ((r_add_a_seen || w_add_a_ack) && (r_add_b_seen || w_add_b_ack)) w_next = ADD_WAIT;
            end
            ADD_WAIT: begin
                w_add_r_ack = w_add_rdy;
                if (w_add_rdy) w_next = (r_k == LAST) ? STORE : MUL_REQ;
            end
            STORE:   w_next = w_last_elem ? DONE : MUL_REQ;
            DONE:    if (input_C_Ack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge input_Clk) begin
        if (input_Reset) begin
            r_c          <= '0;
            r_acc        <= '0;
            r_prod       <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_ab_ack     <= 1'b0;
            r_mul_a_seen <= 1'b0;
            r_mul_b_seen <= 1'b0;
            r_add_a_seen <= 1'b0;
            r_add_b_seen <= 1'b0;
        end else begin
            r_ab_ack <= (r_state == IDLE) && input_Stable;

            if (r_state == MUL_REQ && w_next == MUL_REQ) begin
                r_mul_a_seen <= r_mul_a_seen | w_mul_a_ack;
                r_mul_b_seen <= r_mul_b_seen | w_mul_b_ack;
            end else begin
                r_mul_a_seen <= 1'b0;
                r_mul_b_seen <= 1'b0;
            end

            if (r_state == ADD_REQ && w_next == ADD_REQ) begin
                r_add_a_seen <= r_add_a_seen | w_add_a_ack;
                r_add_b_seen <= r_add_b_seen | w_add_b_ack;
            end else begin
                r_add_a_seen <= 1'b0;
                r_add_b_seen <= 1'b0;
            end

            case (r_state)
                IDLE: if (input_Stable) begin
                    r_i   <= '0;
                    r_j   <= '0;
                    r_k   <= '0;
                    r_acc <= input_Mode ? r_c[W-1:0] : '0;
                end
                MUL_WAIT: if (w_mul_z_stb) r_prod <= w_mul_z;
                ADD_WAIT: if (w_add_rdy) begin
                    r_acc <= w_add_z;
                    if (r_k != LAST) r_k <= r_k + 4'd1;
                end
                STORE: begin
                    // The only place output_C changes during a computation.
                    r_c[(int'(r_i) * N + int'(r_j)) * W +: W] <= r_acc;
                    r_i   <= w_next_i;
                    r_j   <= w_next_j;
                    r_k   <= '0;
                    r_acc <= r_mode ? r_c[(int'(w_next_i) * N + int'(w_next_j)) * W +: W] : '0;
                end
                default: ;
            endcase
        end
    end

    // Captured once per request so later changes on input_A/B cannot leak in.
    always_ff @(posedge input_Clk) begin
        if (r_state == IDLE && input_Stable) begin
            r_a    <= input_A;
            r_b    <= input_B;
            r_mode <= input_Mode;
        end
    end
endmodule
